// File: rtl/fifo_pkg.sv
// Shared constants for the fifo_queue block: default word/pointer widths and depth.
package fifo_pkg;

    localparam int WL_DEFAULT = 6;
    localparam int N_DEFAULT  = 3;
    localparam int DEPTH      = 2 ** N_DEFAULT;

    function automatic int depth_of(input int n);
        return 1 << n;
    endfunction

endpackage

// File: rtl/fifo_mem.sv
// 2**N x Wl storage for fifo_queue: one synchronous write port, one registered read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int Wl = WL_DEFAULT,
    parameter int N  = N_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [N-1:0]  wr_addr,
    input  logic [Wl-1:0] wr_data,
    input  logic          rd_en,
    input  logic [N-1:0]  rd_addr,
    output logic [Wl-1:0] rd_data
);

    logic [Wl-1:0] mem [depth_of(N)];

    // NOTE: the storage array has no reset on purpose; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A read that shares an address with a same-edge write returns the old word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_queue.sv
// First-in-first-out queue: pointer, count and flag control around fifo_mem.
// Define FIFO_QUEUE_STICKY_ERR_EN to make error stay set until reset instead of pulsing.
module fifo_queue
    import fifo_pkg::*;
#(
    parameter int Wl = WL_DEFAULT,
    parameter int N  = N_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [Wl-1:0] dio,
    input  logic          push,
    input  logic          pop,
    output logic [Wl-1:0] q,
    output logic          full,
    output logic          empty,
    output logic [N:0]    count,
    output logic          error
);

    localparam logic [N:0] CAP = (N+1)'(depth_of(N));

    logic [N-1:0] wr_ptr;
    logic [N-1:0] rd_ptr;
    logic         push_ok;
    logic         pop_ok;
    logic         err_now;

    // A push while full is still accepted when a pop frees the slot on the same edge.
    always_comb begin
        full    = (count == CAP);
        empty   = (count == '0);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        err_now = (pop && empty) || (push && !push_ok);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            error  <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + (N+1)'(push_ok) - (N+1)'(pop_ok);
`ifdef FIFO_QUEUE_STICKY_ERR_EN
            error <= error | err_now;
`else
            error <= err_now;
`endif
        end
    end

    fifo_mem #(
        .Wl(Wl),
        .N (N)
    ) u_mem (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (push_ok),
        .wr_addr(wr_ptr),
        .wr_data(dio),
        .rd_en  (pop_ok),
        .rd_addr(rd_ptr),
        .rd_data(q)
    );

endmodule
